// File: rtl/clk_switch_sequencer.sv
// Sequences glitch-free clock-mux select changes: registered select, settle hold-off, done/err reporting.
// Optional feature macro: CLK_SWITCH_ACTIVITY_CHECK_EN (adds clk_activity_i and an output-clock activity check).
module clk_switch_sequencer #(
    parameter int NUM_INPUTS     = 2,
    parameter int RESET_SEL      = 0,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int SelWidth      = $clog2(NUM_INPUTS)
) (
    input  logic                clks_i,
    input  logic                s_reset_synced,
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
    input  logic                clk_activity_i,
`endif
    input  logic                req_valid_i,
    input  logic [SelWidth-1:0] req_sel_i,
    output logic                req_ready_o,
    output logic [SelWidth-1:0] async_sel_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int MaxCycles = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CntWidth  = $clog2(MaxCycles + 1);
    localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SETTLE_CYCLES - 1);

    generate
        if (NUM_INPUTS < 2) begin : g_bad_num_inputs
            $error("clk_switch_sequencer: NUM_INPUTS must be >= 2");
        end
        if (RESET_SEL < 0 || RESET_SEL >= NUM_INPUTS) begin : g_bad_reset_sel
            $error("clk_switch_sequencer: RESET_SEL must be < NUM_INPUTS");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("clk_switch_sequencer: SETTLE_CYCLES must be >= 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("clk_switch_sequencer: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
        ,
        CHECK  = 2'd3
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [SelWidth-1:0] sel_d;
    logic                err_q, err_d;
    logic                sel_invalid;

    assign sel_invalid = (32'(req_sel_i) >= 32'(NUM_INPUTS));

`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
    localparam logic [CntWidth-1:0] TimeoutLoad = CntWidth'(TIMEOUT_CYCLES - 1);

    logic act_sync1_q, act_sync2_q, act_prev_q;
    logic edge_seen_q;
    logic edge_pulse;
    logic arm;

    assign edge_pulse = act_sync2_q ^ act_prev_q;

    // Edge memory is cleared when a switch starts so only activity of the new clock counts.
    always_ff @(posedge clks_i or negedge s_reset_synced) begin
        if (!s_reset_synced) begin
            act_sync1_q <= 1'b0;
            act_sync2_q <= 1'b0;
            act_prev_q  <= 1'b0;
            edge_seen_q <= 1'b0;
        end else begin
            act_sync1_q <= clk_activity_i;
            act_sync2_q <= act_sync1_q;
            act_prev_q  <= act_sync2_q;
            if (arm) begin
                edge_seen_q <= 1'b0;
            end else if (edge_pulse) begin
                edge_seen_q <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clks_i or negedge s_reset_synced) begin
        if (!s_reset_synced) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            async_sel_o <= SelWidth'(RESET_SEL);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            async_sel_o <= sel_d;
        end
    end

    // err_d selects whether the DONE cycle reports done_o or err_o.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = async_sel_o;
        err_d   = err_q;
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
        arm     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (sel_invalid) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (req_sel_i == async_sel_o) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                    end else begin
                        state_d = SETTLE;
                        sel_d   = req_sel_i;
                        cnt_d   = SettleLoad;
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
                        arm     = 1'b1;
`endif
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
                    state_d = CHECK;
                    cnt_d   = TimeoutLoad;
`else
                    state_d = DONE;
                    err_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
            CHECK: begin
                if (edge_seen_q || edge_pulse) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
        busy_o      = (state_q == SETTLE) || (state_q == CHECK);
`else
        busy_o      = (state_q == SETTLE);
`endif
        done_o      = (state_q == DONE) && !err_q;
        err_o       = (state_q == DONE) && err_q;
    end

endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Self-checking bench for clk_switch_sequencer: directed and random requests against a timeline model.
module tb_clk_switch_sequencer;

    localparam int N  = 3;
    localparam int RS = 0;
    localparam int S  = 8;
    localparam int TO = 16;

    logic       clks_i = 1'b0;
    logic       s_reset_synced = 1'b0;
    logic       req_valid_i = 1'b0;
    logic [1:0] req_sel_i = 2'd0;
    logic       req_ready_o;
    logic [1:0] async_sel_o;
    logic       busy_o, done_o, err_o;
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
    logic       clk_activity_i = 1'b0;
`endif

    clk_switch_sequencer #(
        .NUM_INPUTS(N), .RESET_SEL(RS), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clks_i(clks_i),
        .s_reset_synced(s_reset_synced),
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
        .clk_activity_i(clk_activity_i),
`endif
        .req_valid_i(req_valid_i),
        .req_sel_i(req_sel_i),
        .req_ready_o(req_ready_o),
        .async_sel_o(async_sel_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clks_i = ~clks_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: the expected outcome of each request is a set of cycle numbers derived from the rules.
    int model_sel  = RS;
    int ready_from = 0;
    int busy_lo    = 1;
    int busy_hi    = 0;
    int done_at    = -1;
    int err_at     = -1;
    int act_lo     = 1;
    int act_hi     = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
        end
    endtask

    task automatic modelReset();
        model_sel  = RS;
        ready_from = 0;
        busy_lo    = 1;
        busy_hi    = 0;
        done_at    = -1;
        err_at     = -1;
        act_lo     = 1;
        act_hi     = 0;
    endtask

    task automatic modelAccept(input int t, input int sel, input logic toggle);
        if (sel >= N) begin
            err_at     = t + 1;
            ready_from = t + 2;
        end else if (sel == model_sel) begin
            done_at    = t + 1;
            ready_from = t + 2;
        end else begin
            model_sel = sel;
            busy_lo   = t + 1;
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
            if (toggle) begin
                act_lo     = t + 1;
                act_hi     = t + 4;
                busy_hi    = t + S + 1;
                done_at    = t + S + 2;
                ready_from = t + S + 3;
            end else begin
                busy_hi    = t + S + TO;
                err_at     = t + S + TO + 1;
                ready_from = t + S + TO + 2;
            end
`else
            busy_hi    = t + S;
            done_at    = t + S + 1;
            ready_from = t + S + 2;
`endif
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, ".sel"},   32'(async_sel_o), 32'(model_sel));
        checkOutput({phase, ".ready"}, 32'(req_ready_o), 32'(cyc >= ready_from));
        checkOutput({phase, ".busy"},  32'(busy_o),      32'(cyc >= busy_lo && cyc <= busy_hi));
        checkOutput({phase, ".done"},  32'(done_o),      32'(cyc == done_at));
        checkOutput({phase, ".err"},   32'(err_o),       32'(cyc == err_at));
    endtask

    // One clock cycle: drive after the edge, check on the falling edge, then let the model accept.
    task automatic applyStimulus(input logic valid, input int sel, input logic toggle);
        @(posedge clks_i);
        cyc++;
        #1;
        req_valid_i = valid;
        req_sel_i   = 2'(sel);
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
        if (cyc >= act_lo && cyc <= act_hi) clk_activity_i = ~clk_activity_i;
`endif
        @(negedge clks_i);
        checkAll("cyc");
        if (valid && s_reset_synced && cyc >= ready_from) modelAccept(cyc, sel, toggle);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0);
    endtask

    initial begin
        modelReset();
        idleCycles(3);
        s_reset_synced = 1'b1;
        idleCycles(2);

        // Same select, invalid select, then a real switch interrupted by reset.
        applyStimulus(1'b1, 0, 1'b1);
        idleCycles(3);
        applyStimulus(1'b1, 3, 1'b1);
        idleCycles(3);
        applyStimulus(1'b1, 1, 1'b1);
        idleCycles(4);
        #1;
        s_reset_synced = 1'b0;
        #1;
        checkOutput("async_reset.sel",   32'(async_sel_o), 32'(RS));
        checkOutput("async_reset.ready", 32'(req_ready_o), 32'd1);
        checkOutput("async_reset.busy",  32'(busy_o),      32'd0);
        modelReset();
        idleCycles(2);
        s_reset_synced = 1'b1;
        idleCycles(12);

        // Switch to 2, with valid held and sel changing while busy.
        applyStimulus(1'b1, 2, 1'b1);
        for (int i = 0; i < S + 4; i++) applyStimulus(1'b1, (i % 2 == 0) ? 1 : 0, 1'b1);
        idleCycles(3);
        applyStimulus(1'b1, 2, 1'b0);
        idleCycles(3);
`ifdef CLK_SWITCH_ACTIVITY_CHECK_EN
        applyStimulus(1'b1, 0, 1'b0);
        idleCycles(S + TO + 4);
`endif

        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 3) != 0));
        end
        idleCycles(S + TO + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
